// File: rtl/mccoy_acc_core.sv
// Accumulator execution core: one 3-bit-opcode instruction per enabled clock against
// a registered accumulator and a 2**OPND_W entry register file, with status flags.
module mccoy_acc_core #(
  parameter int unsigned DATA_W   = 6,
  parameter int unsigned OPND_W   = 3,
  parameter int unsigned SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [OPND_W+2:0] instr,
  output logic [DATA_W-1:0] acc,
  output logic              zero,
  output logic              neg,
  output logic              ovf
);

  localparam int unsigned NRegs = 2 ** OPND_W;
  localparam logic [DATA_W-1:0] MaxPos = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic [DATA_W-1:0] MinNeg = {1'b1, {(DATA_W - 1){1'b0}}};

  typedef enum logic [2:0] {
    OpLi  = 3'd0,
    OpLsh = 3'd1,
    OpLr  = 3'd2,
    OpAdd = 3'd3,
    OpSub = 3'd4,
    OpNot = 3'd5,
    OpSr  = 3'd6,
    OpSra = 3'd7
  } op_e;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] regs_q [NRegs];
  logic [DATA_W-1:0] regs_d [NRegs];

  op_e                      op;
  logic [OPND_W-1:0]        operand;
  logic [DATA_W-1:0]        rd_val;
  logic [DATA_W:0]          a_ext, b_ext, sum;
  logic                     arith_ovf;
  logic [DATA_W-1:0]        arith_res;
  logic signed [DATA_W-1:0] acc_s;
  logic [DATA_W-1:0]        sra_res;
  logic [DATA_W-1:0]        imm_ext;

  assign op      = op_e'(instr[2:0]);
  assign operand = instr[OPND_W+2:3];
  assign rd_val  = regs_q[operand];
  assign imm_ext = {{(DATA_W - OPND_W){operand[OPND_W-1]}}, operand};

  // Sign-extend by one bit so overflow is judged on the exact result.
  always_comb begin
    a_ext     = {acc_q[DATA_W-1], acc_q};
    b_ext     = {rd_val[DATA_W-1], rd_val};
    sum       = (op == OpSub) ? (a_ext - b_ext) : (a_ext + b_ext);
    arith_ovf = sum[DATA_W] ^ sum[DATA_W-1];
    if ((SATURATE != 0) && arith_ovf) begin
      arith_res = sum[DATA_W] ? MinNeg : MaxPos;
    end else begin
      arith_res = sum[DATA_W-1:0];
    end
  end

  always_comb begin
    acc_s = acc_q;
    if (32'(operand) >= DATA_W) begin
      sra_res = {DATA_W{acc_q[DATA_W-1]}};
    end else begin
      sra_res = acc_s >>> operand;
    end
  end

  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    regs_d = regs_q;
    if (en) begin
      ovf_d = 1'b0;
      unique case (op)
        OpLi:  acc_d = imm_ext;
        OpLsh: acc_d = {acc_q[DATA_W-1-OPND_W:0], operand};
        OpLr:  acc_d = rd_val;
        OpAdd, OpSub: begin
          acc_d = arith_res;
          ovf_d = arith_ovf;
        end
        OpNot: acc_d = ~acc_q;
        OpSr:  regs_d[operand] = acc_q;
        OpSra: acc_d = sra_res;
        default: acc_d = acc_q;
      endcase
    end
    zero_d = (acc_d == '0);
    neg_d  = acc_d[DATA_W-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < int'(NRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      acc_q  <= acc_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
      for (int i = 0; i < int'(NRegs); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign acc  = acc_q;
  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/mccoy_acc_core.md
# mccoy_acc_core

Parametrised accumulator execution core, successor to the fixed 6-bit McCoy datapath. It executes one streamed 3-bit-opcode instruction per enabled clock against an accumulator and a small register file. It adds configurable data and operand widths, subtract, shift-in immediates for wide constants, arithmetic shift, optional saturation, and status flags. It sits behind the chip's IO pins; the accumulator drives the output pins directly.

## Interface
- DATA_W, 6: accumulator and register width; legal range is OPND_W+1 to 16.
- OPND_W, 3: operand-field width. The register file holds NREGS = 2**OPND_W registers.
- SATURATE, 0: 0 means ADD/SUB wrap modulo 2**DATA_W; 1 means ADD/SUB clamp to the signed range.
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high; clears all state immediately.
- en, input, 1: execute enable. When low, the edge is a no-op.
- instr, input, OPND_W+3: field [OPND_W+2:3] is the operand, field [2:0] is the opcode.
- acc, output, DATA_W: accumulator, registered.
- zero, output, 1: registered; equals (acc == 0).
- neg, output, 1: registered; equals acc[DATA_W-1].
- ovf, output, 1: registered; signed overflow of the last executed instruction.

## Operation
- Operand use: treated as a signed immediate `imm` (LI), a raw field (LSH), an unsigned shift count (SRA), or a register index `x` (LR, ADD, SUB, SR).
- Opcodes:
  - 000 LI: acc <= sign-extend(imm) to DATA_W.
  - 001 LSH: acc <= {acc[DATA_W-1-OPND_W:0], operand}. Shifts the raw operand in from the LSB; used to build wide constants.
  - 010 LR: acc <= r[x].
  - 011 ADD: acc <= acc + r[x].
  - 100 SUB: acc <= acc - r[x].
  - 101 NOT: acc <= ~acc; operand ignored.
  - 110 SR: r[x] <= acc; acc unchanged.
  - 111 SRA: acc <= acc >>> operand. A count of DATA_W or more yields all sign bits.
- Arithmetic:
  - Operands are two's complement, DATA_W wide.
  - Signed overflow is detected on the exact DATA_W+1-bit result.
  - SATURATE=0: keep the low DATA_W bits.
  - SATURATE=1: positive overflow gives 2**(DATA_W-1)-1; negative overflow gives -2**(DATA_W-1).
- Flags:
  - ovf is set to 1 only by an ADD or SUB that overflows, in either mode. Every other executed instruction clears it.
  - When en is low, ovf holds.
  - zero and neg always track the registered acc, including after SR and NOT.
- Register file:
  - All NREGS registers are writable; none is hardwired.
  - Reading r[x] in the same edge that writes r[x] is impossible: SR is the only writer and it does not read.
- No state machine beyond single-cycle execute; no stalls and no back-pressure.

## Timing
- Reset values: acc=0, zero=1, neg=0, ovf=0, every r[i]=0.
- Reset takes effect asynchronously, independent of clk.
- Latency: instr and en are sampled on a rising edge. acc, flags and the register file reflect the result after that same edge (1-cycle latency). Back-to-back dependent instructions are legal every cycle.
- The first instruction executed is the one sampled on the first rising edge with reset low.
- An edge coinciding with reset high executes nothing.
- Reset asserted mid-sequence discards the in-flight instruction and clears all state, registers included.
- en=0: acc, flags and registers hold exactly; instr is ignored.

## Test plan
(All with DATA_W=6, OPND_W=3 unless noted.)
- Base program: LI 3, SR x2, LI -4, SR x3, LI 2, ADD x2 gives acc=5. Then LI 2, ADD x3 gives acc=6'b111110 (-2), neg=1, ovf=0.
- Wide constant: LI 1, LSH 5 gives acc=13. Then LI 3, LSH 7 gives acc=31.
- Overflow:
  - Build 31, SR x1, ADD x1 with SATURATE=0: acc=-2, ovf=1.
  - Same sequence with SATURATE=1: acc=31, ovf=1.
  - A following LI 0 gives ovf=0, zero=1.
- SUB/NOT/SRA:
  - LI 2, SR x4, LI -4, SUB x4 gives -6; then NOT gives 5.
  - LI -4, SRA 1 gives -2.
  - LI -4, SRA 7 gives -1.
  - LI 3, SRA 7 gives 0 with zero=1.
- Enable hold: LI 3, then en=0 for 3 edges with instr=ADD x1 gives acc=3 and unchanged flags throughout.
- Async reset:
  - After LI 3, SR x2, pulse reset between edges: acc=0 and zero=1 before the next edge.
  - A subsequent LR x2 gives acc=0.
  - An instruction on an edge while reset is high is not executed.
